// File: rtl/estagio_busca_pkg.sv
// Shared fetch/decode definitions: bubble instruction, reset PC, fetch FSM states, opcodes.
// No logic of its own.
// No flow control here.
package estagio_busca_pkg;

    localparam logic [31:0] INSTR_NOP       = 32'h0000_0013;
    localparam logic [31:0] PC_RESET_PADRAO = 32'h0000_0000;

    localparam logic [6:0] OP_ANDI = 7'b0010011;
    localparam logic [6:0] OP_LH   = 7'b0000011;
    localparam logic [6:0] OP_SH   = 7'b0100011;
    localparam logic [6:0] OP_BNE  = 7'b1100011;

    typedef enum logic [1:0] {
        BUSCA     = 2'd0,
        ESPERA_ID = 2'd1,
        DESCARTE  = 2'd2
    } estado_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ifid_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush (bubble), load and hold.
// Latency: 1 cycle from load/flush to outputs.
// Backpressure: holds contents whenever neither load nor flush is asserted.
module if_id_reg
    import estagio_busca_pkg::*;
#(
    parameter logic [31:0] NOP = INSTR_NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        carga,
    input  logic        descarga,
    input  ifid_t       dado,
    output logic [31:0] instrucao,
    output logic [6:0]  opcode,
    output logic [31:0] pc_id,
    output logic        valido_id
);

    // Flush keeps pc_id so a bubble still carries the last PC seen by decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instrucao <= NOP;
            opcode    <= NOP[6:0];
            pc_id     <= '0;
            valido_id <= 1'b0;
        end else if (descarga) begin
            instrucao <= NOP;
            opcode    <= NOP[6:0];
            valido_id <= 1'b0;
        end else if (carga) begin
            instrucao <= dado.instr;
            opcode    <= dado.instr[6:0];
            pc_id     <= dado.pc;
            valido_id <= 1'b1;
        end
    end

endmodule

// File: rtl/estagio_busca.sv
// Instruction fetch stage: PC, fetch FSM, stall buffer and IF/ID register.
// Latency: word visible in IF/ID one cycle after imem_ready (zero bubbles at 1-cycle memory).
// Backpressure: stall freezes IF/ID; a word returned under stall parks in a one-entry buffer.
module estagio_busca
    import estagio_busca_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_PADRAO,
    parameter logic [31:0] NOP      = INSTR_NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        desvio,
    input  logic [31:0] alvo_desvio,
    output logic [31:0] instrucao,
    output logic [6:0]  opcode,
    output logic [31:0] pc_id,
    output logic        valido_id
);

    estado_t     estado;
    logic [31:0] pc;
    logic [31:0] addr_descarte;
    ifid_t       buffer;
    logic        buf_vld;
    logic        ativo;
    logic        pronto;
    logic        carga;
    logic        descarga;
    ifid_t       dado;

    // ativo delays the first request by one cycle after reset, so a stray
    // ready from an abandoned transaction cannot be mistaken for a fetch.
    assign imem_req  = rst_n & ativo & (estado != ESPERA_ID);
    assign imem_addr = (estado == DESCARTE) ? addr_descarte : pc;
    assign pronto    = imem_req & imem_ready;

    always_comb begin
        dado     = '{instr: imem_rdata, pc: pc};
        carga    = 1'b0;
        descarga = 1'b0;
        if (estado == ESPERA_ID) begin
            dado = buffer;
        end
        if (desvio) begin
            descarga = 1'b1;
        end else if (!stall) begin
            case (estado)
                BUSCA: begin
                    carga    = pronto;
                    descarga = !pronto;
                end
                ESPERA_ID: carga    = buf_vld;
                DESCARTE:  descarga = 1'b1;
                default:   descarga = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc            <= PC_RESET;
            estado        <= BUSCA;
            buffer        <= '0;
            buf_vld       <= 1'b0;
            addr_descarte <= '0;
            ativo         <= 1'b0;
        end else begin
            ativo <= 1'b1;
            if (desvio) begin
                pc      <= alvo_desvio & ~32'd3;
                buf_vld <= 1'b0;
                case (estado)
                    BUSCA: begin
                        // The old address must stay on the bus until memory answers.
                        if (imem_req && !imem_ready) begin
                            estado        <= DESCARTE;
                            addr_descarte <= pc;
                        end else begin
                            estado <= BUSCA;
                        end
                    end
                    ESPERA_ID: estado <= BUSCA;
                    DESCARTE:  estado <= pronto ? BUSCA : DESCARTE;
                    default:   estado <= BUSCA;
                endcase
            end else begin
                case (estado)
                    BUSCA: begin
                        if (pronto) begin
                            if (stall) begin
                                buffer  <= '{instr: imem_rdata, pc: pc};
                                buf_vld <= 1'b1;
                                estado  <= ESPERA_ID;
                            end else begin
                                pc <= pc + 32'd4;
                            end
                        end
                    end
                    ESPERA_ID: begin
                        if (!stall) begin
                            pc      <= pc + 32'd4;
                            buf_vld <= 1'b0;
                            estado  <= BUSCA;
                        end
                    end
                    DESCARTE: begin
                        if (pronto) begin
                            estado <= BUSCA;
                        end
                    end
                    default: estado <= BUSCA;
                endcase
            end
        end
    end

    if_id_reg #(
        .NOP(NOP)
    ) u_if_id (
        .clk       (clk),
        .rst_n     (rst_n),
        .carga     (carga),
        .descarga  (descarga),
        .dado      (dado),
        .instrucao (instrucao),
        .opcode    (opcode),
        .pc_id     (pc_id),
        .valido_id (valido_id)
    );

endmodule

// File: doc/estagio_busca.md
ESTAGIO_BUSCA -- requirements
Module: estagio_busca

Interface
REQ-001 Parameter PC_RESET, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP, 32'h0000_0013, bubble instruction (ADDI x0,x0,0) driven into IF/ID.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 imem_addr  output  32  fetch address (current PC).
REQ-006 imem_req  output  1  fetch request; address held stable while asserted until imem_ready.
REQ-007 imem_rdata  input  32  instruction word, valid only when imem_ready=1.
REQ-008 imem_ready  input  1  memory completes the request this cycle; latency 1..N cycles.
REQ-009 stall  input  1  hazard unit: hold IF/ID contents and PC.
REQ-010 desvio  input  1  taken branch (BNE) from EX: redirect and flush.
REQ-011 alvo_desvio  input  32  branch target; bits [1:0] ignored (treated as 00).
REQ-012 instrucao  output  32  registered IF/ID instruction, feeds decode and immediate generation.
REQ-013 opcode  output  7  registered copy of instrucao[6:0].
REQ-014 pc_id  output  32  PC of instrucao.
REQ-015 valido_id  output  1  instrucao is a real fetched instruction (0 = bubble).

Function
REQ-016 FSM states: BUSCA (request outstanding), ESPERA_ID (fetched word held in internal buffer while stalled), DESCARTE (redirect pending; drop in-flight response).
REQ-017 BUSCA: imem_req=1, imem_addr=pc.
REQ-018 BUSCA, imem_ready=1, stall=0, desvio=0: IF/ID <= {imem_rdata, pc}, valido_id<=1, pc<=pc+4, stay BUSCA; zero-bubble throughput at 1-cycle memory latency.
REQ-019 BUSCA, imem_ready=1, stall=1, desvio=0: capture imem_rdata and pc into buffer, IF/ID unchanged, go ESPERA_ID.
REQ-020 BUSCA, imem_ready=0, stall=0, desvio=0: IF/ID <= {NOP, pc_id unchanged}, valido_id<=0.
REQ-021 Any state, stall=1, desvio=0: instrucao, opcode, pc_id, valido_id unchanged.
REQ-022 ESPERA_ID: imem_req=0; when stall=0, IF/ID <= buffer, valido_id<=1, pc<=pc+4, go BUSCA.
REQ-023 desvio=1 has priority over stall and over imem_ready: IF/ID <= NOP, valido_id<=0, pc<={alvo_desvio[31:2],2'b00}, buffer invalidated.
REQ-024 desvio=1 in BUSCA with imem_ready=0: go DESCARTE; imem_req stays 1 with old address.
REQ-025 desvio=1 in BUSCA with imem_ready=1, or in ESPERA_ID: returned/buffered word discarded, go BUSCA with new pc.
REQ-026 DESCARTE: imem_req=1 with old address; on imem_ready discard imem_rdata, go BUSCA next cycle using new pc; IF/ID holds bubble meanwhile.
REQ-027 desvio=1 again in DESCARTE: pc<=newest target, remain DESCARTE.
REQ-028 PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-029 opcode SHALL always equal instrucao[6:0].

Reset
REQ-030 rst_n=0 at rising edge: pc<=PC_RESET, state<=BUSCA, buffer invalid, instrucao<=NOP, opcode<=7'b0010011, pc_id<=0, valido_id<=0.
REQ-031 imem_req=0 in every cycle rst_n=0; first request issued the cycle after rst_n returns to 1.
REQ-032 Reset mid-request abandons it; a late imem_ready after reset SHALL be ignored unless imem_req=1.

Structure
REQ-033 Shared package holds NOP, PC_RESET default, state enum (BUSCA, ESPERA_ID, DESCARTE) and opcode constants (ANDI 0010011, LH 0000011, SH 0100011, BNE 1100011) used by decode and immediate generation.
REQ-034 One sub-module if_id_reg (IF/ID register with load/hold/flush controls); FSM, buffer and PC stay in estagio_busca.

Verification
REQ-035 Reset then 1-cycle memory returning 32'h00A0_0113 at 0, 32'h0021_1023 at 4: instrucao matches in consecutive cycles, pc_id 0 then 4, valido_id=1, opcode 0010011 then 0100011.
REQ-036 stall=1 for 3 cycles while word at 8 returns: IF/ID frozen, imem_req=0 in ESPERA_ID, word at 8 appears cycle after stall drops, no word lost or duplicated.
REQ-037 desvio=1, alvo_desvio=32'h0000_0043 with 3-cycle memory, request pending: stale response dropped, next imem_addr=32'h0000_0040, valido_id=0 until target word arrives.
REQ-038 desvio=1 and stall=1 same cycle: flush wins, instrucao=NOP, valido_id=0, pc=target.
REQ-039 PC_RESET=32'hFFFF_FFFC: second fetch address 32'h0000_0000.
REQ-040 rst_n=0 asserted during pending 3-cycle request: outputs reach reset values next edge, late imem_ready ignored, fetch restarts at PC_RESET.
